// File: rtl/exception_pkg.sv
// Shared types for the exception sequencer: FSM states, the latched request
// record, the exccode constants and the "code carries a bad address" predicate.
package exception_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } seq_state_e;

  localparam logic [4:0] CODE_MOD  = 5'd1;
  localparam logic [4:0] CODE_TLBL = 5'd2;
  localparam logic [4:0] CODE_TLBS = 5'd3;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;

  // Everything captured at accept; held stable until the sequence ends.
  typedef struct packed {
    logic        is_exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic [31:0] badvaddr;
    logic        in_ds;
    logic [31:0] location;
    logic [31:0] epc;
    logic        status_exl;
  } exc_req_t;

  function automatic logic has_badvaddr(input logic [4:0] code);
    return (code == CODE_MOD)  || (code == CODE_TLBL) || (code == CODE_TLBS) ||
           (code == CODE_ADEL) || (code == CODE_ADES);
  endfunction

endpackage

// File: rtl/exception_seq_if.sv
// Commit-stage <-> exception sequencer bundle. EXCEPTION_SEQ_PERF_EN adds the
// exc_count / eret_count counter outputs.
interface exception_seq_if;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_badvaddr;
  logic        exc_in_delay_slot;
  logic [31:0] exc_location;
  logic        eret_req;
  logic [31:0] epc_in;
  logic        status_exl;
  logic        mem_busy;

  logic        flush;
  logic        stall;
  logic        cp0_we;
  logic [31:0] epc_wr;
  logic [4:0]  exccode_wr;
  logic        bd_wr;
  logic        epc_we;
  logic        badvaddr_we;
  logic [31:0] badvaddr_wr;
  logic        exl_set;
  logic        exl_clr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        drain_timeout;
  logic        busy;
  logic        ack;
`ifdef EXCEPTION_SEQ_PERF_EN
  logic [31:0] exc_count;
  logic [31:0] eret_count;
`endif

  modport master (
    output exc_valid, exc_code, exc_pc, exc_badvaddr, exc_in_delay_slot,
           exc_location, eret_req, epc_in, status_exl, mem_busy,
`ifdef EXCEPTION_SEQ_PERF_EN
    input  exc_count, eret_count,
`endif
    input  flush, stall, cp0_we, epc_wr, exccode_wr, bd_wr, epc_we,
           badvaddr_we, badvaddr_wr, exl_set, exl_clr, redirect_valid,
           redirect_pc, drain_timeout, busy, ack
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_badvaddr, exc_in_delay_slot,
           exc_location, eret_req, epc_in, status_exl, mem_busy,
`ifdef EXCEPTION_SEQ_PERF_EN
    output exc_count, eret_count,
`endif
    output flush, stall, cp0_we, epc_wr, exccode_wr, bd_wr, epc_we,
           badvaddr_we, badvaddr_wr, exl_set, exl_clr, redirect_valid,
           redirect_pc, drain_timeout, busy, ack
  );
endinterface

// File: rtl/exception_seq_drain.sv
// Drain-cycle counter with a forced exit after DRAIN_MAX busy cycles and a
// sticky timeout flag that only reset clears.
module exception_seq_drain #(
  parameter int DRAIN_MAX = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic active,
  input  logic mem_busy,
  output logic done,
  output logic timeout
);
  localparam int CW = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);

  logic [CW-1:0] cnt;
  logic          hit;

  // cnt counts completed DRAIN cycles, so the current one is cnt+1.
  assign hit  = active && mem_busy && (int'(cnt) >= DRAIN_MAX - 1);
  assign done = active && (!mem_busy || hit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (start)
        cnt <= '0;
      else if (active && (int'(cnt) < DRAIN_MAX))
        cnt <= cnt + 1'b1;
      if (hit)
        timeout <= 1'b1;
    end
  end
endmodule

// File: rtl/exception_seq.sv
// Exception / ERET sequencer: accept, drain the pipeline, commit CP0, redirect
// fetch. Define EXCEPTION_SEQ_PERF_EN to add exception/ERET commit counters.
module exception_seq
  import exception_pkg::*;
#(
  parameter int DRAIN_MAX = 255
) (
  input  logic           clk,
  input  logic           resetn,
  exception_seq_if.slave bus
);
  seq_state_e state, state_nxt;
  exc_req_t   req_q;
  logic       accept, in_drain, drain_done;

  // Exception wins over a simultaneous ERET: is_exc is taken from exc_valid.
  assign accept   = (state == ST_IDLE) && (bus.exc_valid || bus.eret_req);
  assign in_drain = (state == ST_DRAIN);
  assign bus.ack  = accept && resetn;
  assign bus.busy = (state != ST_IDLE);

  exception_seq_drain #(.DRAIN_MAX(DRAIN_MAX)) u_drain (
    .clk      (clk),
    .resetn   (resetn),
    .start    (accept),
    .active   (in_drain),
    .mem_busy (bus.mem_busy),
    .done     (drain_done),
    .timeout  (bus.drain_timeout)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        req_q <= '{is_exc:     bus.exc_valid,
                   code:       bus.exc_code,
                   pc:         bus.exc_pc,
                   badvaddr:   bus.exc_badvaddr,
                   in_ds:      bus.exc_in_delay_slot,
                   location:   bus.exc_location,
                   epc:        bus.epc_in,
                   status_exl: bus.status_exl};
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.flush          = 1'b0;
    bus.stall          = 1'b0;
    bus.cp0_we         = 1'b0;
    bus.epc_wr         = '0;
    bus.exccode_wr     = '0;
    bus.bd_wr          = 1'b0;
    bus.epc_we         = 1'b0;
    bus.badvaddr_we    = 1'b0;
    bus.badvaddr_wr    = '0;
    bus.exl_set        = 1'b0;
    bus.exl_clr        = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        if (drain_done) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        bus.stall  = 1'b1;
        bus.cp0_we = 1'b1;
        state_nxt  = ST_REDIRECT;
        if (req_q.is_exc) begin
          bus.exccode_wr = req_q.code;
          bus.exl_set    = 1'b1;
          // Nested exception (EXL already set) must not overwrite EPC/BD.
          if (!req_q.status_exl) begin
            bus.epc_we = 1'b1;
            bus.bd_wr  = req_q.in_ds;
            bus.epc_wr = req_q.in_ds ? req_q.pc - 32'd4 : req_q.pc;
          end
          if (has_badvaddr(req_q.code)) begin
            bus.badvaddr_we = 1'b1;
            bus.badvaddr_wr = req_q.badvaddr;
          end
        end else begin
          bus.exl_clr = 1'b1;
        end
      end
      ST_REDIRECT: begin
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = req_q.is_exc ? req_q.location : req_q.epc;
        state_nxt          = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef EXCEPTION_SEQ_PERF_EN
  logic [31:0] exc_cnt_q, eret_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_cnt_q  <= '0;
      eret_cnt_q <= '0;
    end else if (state == ST_COMMIT) begin
      if (req_q.is_exc) exc_cnt_q  <= exc_cnt_q + 32'd1;
      else              eret_cnt_q <= eret_cnt_q + 32'd1;
    end
  end

  assign bus.exc_count  = exc_cnt_q;
  assign bus.eret_count = eret_cnt_q;
`else
  // Counters compiled out; the sequencer itself is unchanged.
`endif
endmodule

// File: tb/tb_exception_seq.sv
// Randomized bench for exception_seq with a cycle-level behavioural model plus
// directed literal checks on latency, EPC/BD, ERET, drain timeout and reset.
module tb_exception_seq;
  localparam int DMAX = 8;

  logic clk, resetn;
  exception_seq_if bus();

  exception_seq #(.DRAIN_MAX(DMAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: phase 0 idle,1 drain,2 commit,3 redirect
  int          m_ph = 0;
  int          m_d = 0;
  logic        m_to = 1'b0;
  logic        m_exc, m_ds, m_exl;
  logic [4:0]  m_code;
  logic [31:0] m_pc, m_bva, m_loc, m_epc;
  logic [31:0] m_ecnt = '0, m_rcnt = '0;

  logic        e_ack, e_flush, e_stall, e_we, e_epcwe, e_bd, e_bvawe, e_set, e_clr, e_rv, e_busy;
  logic [4:0]  e_code;
  logic [31:0] e_epc, e_bva, e_rpc;

  always @(negedge clk) begin
    {e_ack, e_flush, e_stall, e_we, e_epcwe, e_bd, e_bvawe, e_set, e_clr, e_rv, e_busy} = '0;
    e_code = '0; e_epc = '0; e_bva = '0; e_rpc = '0;
    if (resetn) begin
      e_busy = (m_ph != 0);
      if (m_ph == 0) e_ack = bus.exc_valid || bus.eret_req;
      if (m_ph == 1) begin e_flush = 1'b1; e_stall = 1'b1; end
      if (m_ph == 2) begin
        e_stall = 1'b1; e_we = 1'b1;
        if (m_exc) begin
          e_set = 1'b1; e_code = m_code;
          if (!m_exl) begin
            e_epcwe = 1'b1; e_bd = m_ds;
            e_epc = m_ds ? m_pc - 32'd4 : m_pc;
          end
          if (m_code >= 5'd1 && m_code <= 5'd5) begin e_bvawe = 1'b1; e_bva = m_bva; end
        end else e_clr = 1'b1;
      end
      if (m_ph == 3) begin
        e_stall = 1'b1; e_rv = 1'b1;
        e_rpc = m_exc ? m_loc : m_epc;
      end
    end
    chk1("ack", bus.ack, e_ack);
    chk1("flush", bus.flush, e_flush);
    chk1("stall", bus.stall, e_stall);
    chk1("cp0_we", bus.cp0_we, e_we);
    chk1("epc_we", bus.epc_we, e_epcwe);
    chk32("epc_wr", bus.epc_wr, e_epc);
    chk32("exccode_wr", 32'(bus.exccode_wr), 32'(e_code));
    chk1("bd_wr", bus.bd_wr, e_bd);
    chk1("badvaddr_we", bus.badvaddr_we, e_bvawe);
    chk32("badvaddr_wr", bus.badvaddr_wr, e_bva);
    chk1("exl_set", bus.exl_set, e_set);
    chk1("exl_clr", bus.exl_clr, e_clr);
    chk1("redirect_valid", bus.redirect_valid, e_rv);
    chk32("redirect_pc", bus.redirect_pc, e_rpc);
    chk1("busy", bus.busy, e_busy);
    chk1("drain_timeout", bus.drain_timeout, resetn ? m_to : 1'b0);
`ifdef EXCEPTION_SEQ_PERF_EN
    chk32("exc_count", bus.exc_count, resetn ? m_ecnt : 32'd0);
    chk32("eret_count", bus.eret_count, resetn ? m_rcnt : 32'd0);
`endif
    // advance the model to the state after the coming rising edge
    if (!resetn) begin
      m_ph = 0; m_to = 1'b0; m_ecnt = '0; m_rcnt = '0;
    end else if (m_ph == 0) begin
      if (bus.exc_valid || bus.eret_req) begin
        m_ph = 1; m_d = 0;
        m_exc = bus.exc_valid; m_code = bus.exc_code; m_pc = bus.exc_pc;
        m_bva = bus.exc_badvaddr; m_ds = bus.exc_in_delay_slot;
        m_loc = bus.exc_location; m_epc = bus.epc_in; m_exl = bus.status_exl;
      end
    end else if (m_ph == 1) begin
      m_d++;
      if (!bus.mem_busy) m_ph = 2;
      else if (m_d >= DMAX) begin m_ph = 2; m_to = 1'b1; end
    end else if (m_ph == 2) begin
      m_ph = 3;
      if (m_exc) m_ecnt = m_ecnt + 32'd1;
      else       m_rcnt = m_rcnt + 32'd1;
    end else m_ph = 0;
  end

  // ---------------- directed helpers
  // Issue one request; mem_busy stays high for busy_cyc cycles counted from
  // the accept cycle. Returns at the falling edge of the COMMIT cycle.
  task automatic req(input logic ev, input logic er, input logic [4:0] code,
                     input logic [31:0] pc, input logic [31:0] bva, input logic ds,
                     input logic [31:0] loc, input logic [31:0] epc, input logic exl,
                     input int busy_cyc, output int dcyc);
    logic found;
    bus.exc_valid = ev; bus.eret_req = er; bus.exc_code = code; bus.exc_pc = pc;
    bus.exc_badvaddr = bva; bus.exc_in_delay_slot = ds; bus.exc_location = loc;
    bus.epc_in = epc; bus.status_exl = exl; bus.mem_busy = (busy_cyc > 0);
    @(negedge clk);
    chk1("accept_ack", bus.ack, 1'b1);
    @(posedge clk); #1;
    bus.exc_valid = 1'b0; bus.eret_req = 1'b0;
    bus.exc_pc = $urandom; bus.epc_in = $urandom; bus.exc_location = $urandom;
    bus.exc_badvaddr = $urandom; bus.exc_code = 5'($urandom); bus.status_exl = ~exl;
    bus.exc_in_delay_slot = ~ds;
    dcyc = 0; found = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      bus.mem_busy = (j < busy_cyc);
      @(negedge clk);
      if (bus.cp0_we) begin found = 1'b1; break; end
      if (bus.flush) dcyc++;
      @(posedge clk); #1;
    end
    chk1("commit_reached", found, 1'b1);
  endtask

  task automatic redirect(input logic [31:0] rpc);
    @(posedge clk); #1;
    bus.mem_busy = 1'b0;
    @(negedge clk);
    chk1("redir_valid", bus.redirect_valid, 1'b1);
    chk32("redir_pc", bus.redirect_pc, rpc);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    resetn = 1'b1;
    bus.exc_valid = 1'b0; bus.eret_req = 1'b0; bus.exc_code = '0; bus.exc_pc = '0;
    bus.exc_badvaddr = '0; bus.exc_in_delay_slot = 1'b0; bus.exc_location = '0;
    bus.epc_in = '0; bus.status_exl = 1'b0; bus.mem_busy = 1'b0;
    #1 resetn = 1'b0;
    bus.exc_valid = 1'b1;
    @(negedge clk);
    chk1("rst_ack", bus.ack, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_stall", bus.stall, 1'b0);
    chk1("rst_timeout", bus.drain_timeout, 1'b0);
    @(posedge clk); #1;
    bus.exc_valid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;

    // basic exception, minimum latency
    req(1'b1, 1'b0, 5'd12, 32'hBFC00100, 32'h0, 1'b0, 32'hBFC00380, 32'h0, 1'b0, 0, d);
    chk32("t1_drain_len", d, 1);
    chk32("t1_epc_wr", bus.epc_wr, 32'hBFC00100);
    chk32("t1_exccode", 32'(bus.exccode_wr), 32'd12);
    chk1("t1_bva_we", bus.badvaddr_we, 1'b0);
    chk1("t1_epc_we", bus.epc_we, 1'b1);
    redirect(32'hBFC00380);

    // delay slot
    req(1'b1, 1'b0, 5'd10, 32'h80000004, 32'h0, 1'b1, 32'h80000180, 32'h0, 1'b0, 0, d);
    chk32("t2_epc_wr", bus.epc_wr, 32'h80000000);
    chk1("t2_bd_wr", bus.bd_wr, 1'b1);
    redirect(32'h80000180);

    // ERET
    req(1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 32'hDEAD0000, 32'h80001234, 1'b1, 0, d);
    chk1("t3_exl_clr", bus.exl_clr, 1'b1);
    chk1("t3_exl_set", bus.exl_set, 1'b0);
    chk1("t3_epc_we", bus.epc_we, 1'b0);
    redirect(32'h80001234);

    // exception and ERET together: exception wins
    req(1'b1, 1'b1, 5'd8, 32'h80000100, 32'h0, 1'b0, 32'h80000180, 32'h80009999, 1'b0, 0, d);
    chk1("t4_exl_set", bus.exl_set, 1'b1);
    chk1("t4_exl_clr", bus.exl_clr, 1'b0);
    redirect(32'h80000180);

    // mem_busy held for 5 cycles
    req(1'b1, 1'b0, 5'd12, 32'h80000200, 32'h0, 1'b0, 32'h80000180, 32'h0, 1'b0, 5, d);
    chk32("t5_drain_len", d, 5);
    chk1("t5_timeout", bus.drain_timeout, 1'b0);
    redirect(32'h80000180);

    // mem_busy stuck: forced commit after DRAIN_MAX cycles
    req(1'b1, 1'b0, 5'd12, 32'h80000300, 32'h0, 1'b0, 32'h80000180, 32'h0, 1'b0, 1000, d);
    chk32("t6_drain_len", d, DMAX);
    chk1("t6_timeout", bus.drain_timeout, 1'b1);
    redirect(32'h80000180);

    // AdEL with EXL already set
    req(1'b1, 1'b0, 5'd4, 32'h80000400, 32'h00000003, 1'b1, 32'h80000180, 32'h0, 1'b1, 0, d);
    chk1("t7_bva_we", bus.badvaddr_we, 1'b1);
    chk32("t7_bva_wr", bus.badvaddr_wr, 32'h00000003);
    chk1("t7_epc_we", bus.epc_we, 1'b0);
    chk1("t7_bd_wr", bus.bd_wr, 1'b0);
    chk1("t7_timeout_sticky", bus.drain_timeout, 1'b1);
    redirect(32'h80000180);

    // reset in the middle of COMMIT
    req(1'b1, 1'b0, 5'd2, 32'h80000500, 32'h1000, 1'b0, 32'h80000180, 32'h0, 1'b0, 0, d);
    #2 resetn = 1'b0;
    #1;
    chk1("t8_busy", bus.busy, 1'b0);
    chk1("t8_cp0_we", bus.cp0_we, 1'b0);
    chk1("t8_stall", bus.stall, 1'b0);
    chk1("t8_bva_we", bus.badvaddr_we, 1'b0);
    chk1("t8_timeout", bus.drain_timeout, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;

    // randomized traffic, checked by the model every cycle
    begin
      int bias = 3;
      for (int i = 0; i < 3000; i++) begin
        @(posedge clk); #1;
        if (i % 150 == 0) bias = $urandom_range(10);
        resetn                = ($urandom_range(399) != 0);
        bus.exc_valid         = ($urandom_range(3) == 0);
        bus.eret_req          = ($urandom_range(3) == 0);
        bus.exc_code          = ($urandom_range(1) == 0) ? 5'($urandom_range(6)) : 5'($urandom);
        bus.exc_pc            = $urandom;
        bus.exc_badvaddr      = $urandom;
        bus.exc_in_delay_slot = $urandom_range(1) == 1;
        bus.exc_location      = $urandom;
        bus.epc_in            = $urandom;
        bus.status_exl        = $urandom_range(1) == 1;
        bus.mem_busy          = ($urandom_range(9) < bias);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      bus.exc_valid = 1'b0; bus.eret_req = 1'b0;
      repeat (3) @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
